// File: rtl/fir_line_ctrl.sv
// Line-buffer sequencer for the 5x5 FIR: ring-rotating write ownership over four line BRAMs,
// window qualification and delayed syncs. Define FIR_BORDER_ZERO_EN for zero-padded border windows.
module fir_line_ctrl #(
   parameter int MAX_COLS = 1604,
   parameter int COL_W    = 11,
   parameter int ROW_W    = 10,
   parameter int PIPE_LAT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dv_i,
   input  logic             hs_i,
   input  logic             vs_i,
   output logic [COL_W-1:0] wr_addr,
   output logic [3:0]       wr_we,
   output logic [COL_W-1:0] rd_addr,
   output logic [1:0]       rd_rot,
   output logic [COL_W-1:0] x_index,
   output logic [ROW_W-1:0] y_index,
   output logic             win_valid,
   output logic             pad_o,
   output logic             ovf_o,
   output logic             dv_o,
   output logic             hs_o,
   output logic             vs_o,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      LINE       = 2'd1,
      BLANK      = 2'd2
   } state_t;

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(MAX_COLS - 1);

   state_t              state;
   logic [3:0]          wr_sel;
   logic [2:0]          lines_filled;
   logic                line_full;
   logic                hs_dly;
   logic [PIPE_LAT-1:0] dv_pipe, hs_pipe, vs_pipe, win_pipe, pad_pipe;

   logic                hs_edge, pix, eff_full, full_win, win_in, pad_in;
   logic [COL_W-1:0]    eff_x;
   logic [3:0]          eff_sel;
   logic [2:0]          eff_lines;

   // A line advance in the same cycle as a pixel is applied before the pixel is placed.
   always_comb begin
      hs_edge   = hs_i & ~hs_dly & ~vs_i & (state != WAIT_FRAME);
      pix       = dv_i & ~vs_i;
      eff_x     = hs_edge ? '0 : x_index;
      eff_sel   = hs_edge ? {wr_sel[2:0], wr_sel[3]} : wr_sel;
      eff_full  = hs_edge ? 1'b0 : line_full;
      eff_lines = (hs_edge && lines_filled != 3'd4) ? lines_filled + 3'd1 : lines_filled;
      full_win  = (eff_lines == 3'd4) && (eff_x >= COL_W'(4));
`ifdef FIR_BORDER_ZERO_EN
      win_in    = pix;
      pad_in    = pix & ~full_win;
`else
      win_in    = pix & full_win;
      pad_in    = 1'b0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= WAIT_FRAME;
         wr_sel       <= 4'b0001;
         lines_filled <= '0;
         line_full    <= 1'b0;
         hs_dly       <= 1'b0;
         wr_addr      <= '0;
         rd_addr      <= '0;
         wr_we        <= '0;
         rd_rot       <= '0;
         x_index      <= '0;
         y_index      <= '0;
         ovf_o        <= 1'b0;
         dv_pipe      <= '0;
         hs_pipe      <= '0;
         vs_pipe      <= '0;
         win_pipe     <= '0;
         pad_pipe     <= '0;
      end else begin
         hs_dly   <= hs_i;
         dv_pipe  <= PIPE_LAT'({dv_pipe, dv_i});
         hs_pipe  <= PIPE_LAT'({hs_pipe, hs_i});
         vs_pipe  <= PIPE_LAT'({vs_pipe, vs_i});
         win_pipe <= PIPE_LAT'({win_pipe, win_in});
         pad_pipe <= PIPE_LAT'({pad_pipe, pad_in});
         wr_we    <= '0;
         if (vs_i) begin
            state        <= WAIT_FRAME;
            x_index      <= '0;
            y_index      <= '0;
            rd_rot       <= '0;
            lines_filled <= '0;
            ovf_o        <= 1'b0;
            wr_sel       <= 4'b0001;
            line_full    <= 1'b0;
         end else begin
            if (hs_edge) begin
               state        <= BLANK;
               x_index      <= '0;
               y_index      <= y_index + ROW_W'(1);
               wr_sel       <= eff_sel;
               rd_rot       <= rd_rot + 2'd1;
               lines_filled <= eff_lines;
               line_full    <= 1'b0;
            end
            if (pix) begin
               state <= LINE;
               // Once the last column is written the line is full; extra pixels only flag overflow.
               if (eff_full) begin
                  ovf_o <= 1'b1;
               end else begin
                  wr_addr <= eff_x;
                  rd_addr <= eff_x;
                  wr_we   <= eff_sel;
                  if (eff_x == LAST_COL) line_full <= 1'b1;
                  else                   x_index   <= eff_x + COL_W'(1);
               end
            end
         end
      end
   end

   assign dv_o      = dv_pipe[PIPE_LAT-1];
   assign hs_o      = hs_pipe[PIPE_LAT-1];
   assign vs_o      = vs_pipe[PIPE_LAT-1];
   assign win_valid = win_pipe[PIPE_LAT-1];
   assign pad_o     = pad_pipe[PIPE_LAT-1];
   assign state_dbg = state;

endmodule

// File: tb/tb_fir_line_ctrl.sv
// Directed bench for fir_line_ctrl: ring rotation, overflow, coincident events, async reset,
// and per-cycle sync/window alignment against an expected queue.
module tb_fir_line_ctrl;

  localparam int MAX_COLS = 1604;
  localparam int COL_W    = 11;
  localparam int ROW_W    = 10;
  localparam int PIPE_LAT = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             dv_i, hs_i, vs_i;
  logic [COL_W-1:0] wr_addr, rd_addr, x_index;
  logic [3:0]       wr_we;
  logic [1:0]       rd_rot, state_dbg;
  logic [ROW_W-1:0] y_index;
  logic             win_valid, pad_o, ovf_o, dv_o, hs_o, vs_o;

  int n_vec = 0;
  int n_bad = 0;
  int win_cnt, pad_cnt, we_cnt;

  // reference model of line/column position, used only for the window expectations
  int   m_line, m_col;
  logic m_wait, m_hs_prev;
  logic [4:0] exp_q[$];

  fir_line_ctrl #(
    .MAX_COLS(MAX_COLS), .COL_W(COL_W), .ROW_W(ROW_W), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .rst(rst), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .wr_addr(wr_addr), .wr_we(wr_we), .rd_addr(rd_addr), .rd_rot(rd_rot),
    .x_index(x_index), .y_index(y_index), .win_valid(win_valid), .pad_o(pad_o),
    .ovf_o(ovf_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_line = 0; m_col = 0; m_wait = 1'b1; m_hs_prev = 1'b0;
    exp_q.delete();
  endtask

  // one clock: apply inputs, advance, then check the sync/window outputs due this cycle
  task automatic cyc(input logic dv, input logic hs, input logic vs);
    logic [4:0] e, got;
    logic edge_m;
    dv_i = dv; hs_i = hs; vs_i = vs;
    e = {dv, hs, vs, 2'b00};
    edge_m = hs & ~m_hs_prev & ~vs & ~m_wait;
    m_hs_prev = hs;
    if (vs) begin
      m_line = 0; m_col = 0; m_wait = 1'b1;
    end else begin
      if (edge_m) begin m_line++; m_col = 0; end
      if (dv) begin
`ifdef FIR_BORDER_ZERO_EN
        e[1] = 1'b1;
        e[0] = (m_line < 4) || (m_col < 4);
`else
        e[1] = (m_line >= 4) && (m_col >= 4);
`endif
        m_col++;
        m_wait = 1'b0;
      end
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (exp_q.size() >= PIPE_LAT) begin
      e = exp_q.pop_front();
      got = {dv_o, hs_o, vs_o, win_valid, pad_o};
      if (got != 5'd0 || e != 5'd0) chk("sync_win", got, e);
      win_cnt += int'(win_valid);
      pad_cnt += int'(pad_o);
    end
  endtask

  task automatic send_line(input int n, input logic [3:0] we);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk("wr_we", wr_we, we);
      chk("wr_addr", wr_addr, i);
      chk("rd_addr", rd_addr, i);
      chk("x_index", x_index, i + 1);
    end
    cyc(1'b0, 1'b0, 1'b0);
    chk("we_idle", wr_we, 0);
  endtask

  task automatic end_line();
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic vs_pulse();
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    win_cnt = 0; pad_cnt = 0; we_cnt = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {wr_addr, wr_we, rd_addr, rd_rot, x_index, y_index,
                     win_valid, pad_o, ovf_o, dv_o, hs_o, vs_o}, 64'd0);
    chk("rst_state", state_dbg, 0);
    rst = 1'b0;

    // three lines after a frame start: ring bits 0001, 0010, 0100
    win_cnt = 0; pad_cnt = 0;
    vs_pulse();
    for (int l = 0; l < 3; l++) begin
      send_line(8, 4'(1 << l));
      chk("state_line", state_dbg, 1);
      end_line();
      chk("rd_rot", rd_rot, l + 1);
      chk("y_index", y_index, l + 1);
      chk("state_blank", state_dbg, 2);
    end
`ifdef FIR_BORDER_ZERO_EN
    chk("win_cnt_3l", win_cnt, 24);
    chk("pad_cnt_3l", pad_cnt, 24);
`else
    chk("win_cnt_3l", win_cnt, 0);
    chk("pad_cnt_3l", pad_cnt, 0);
`endif

    // six lines: windows become complete from line 4, column 4
    win_cnt = 0; pad_cnt = 0;
    vs_pulse();
    for (int l = 0; l < 6; l++) begin
      send_line(8, 4'(1 << (l % 4)));
      end_line();
      chk("rd_rot6", rd_rot, (l + 1) % 4);
    end
`ifdef FIR_BORDER_ZERO_EN
    chk("win_cnt_6l", win_cnt, 48);
    chk("pad_cnt_6l", pad_cnt, 40);
`else
    chk("win_cnt_6l", win_cnt, 8);
    chk("pad_cnt_6l", pad_cnt, 0);
`endif

    // overflow: MAX_COLS+2 pixels on one line
    vs_pulse();
    we_cnt = 0;
    for (int i = 0; i < MAX_COLS + 2; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      we_cnt += (wr_we != 4'd0) ? 1 : 0;
      if (i < MAX_COLS) begin
        chk("ovf_we", wr_we, 4'b0001);
        chk("ovf_addr", wr_addr, i);
      end else begin
        chk("ovf_supp", wr_we, 0);
        chk("ovf_hold", wr_addr, 1603);
      end
    end
    chk("ovf_cnt", we_cnt, 1604);
    chk("ovf_set", ovf_o, 1);
    chk("ovf_x", x_index, 1603);
    end_line();
    chk("ovf_sticky", ovf_o, 1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("ovf_clr", ovf_o, 0);
    cyc(1'b0, 1'b0, 1'b0);

    // hs edge coincident with dv, then vs coincident with hs edge and dv
    send_line(8, 4'b0001);
    cyc(1'b1, 1'b1, 1'b0);
    chk("co_addr", wr_addr, 0);
    chk("co_we", wr_we, 4'b0010);
    chk("co_x", x_index, 1);
    chk("co_y", y_index, 1);
    chk("co_rot", rd_rot, 1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("co_addr2", wr_addr, 1);
    chk("co_we2", wr_we, 4'b0010);
    cyc(1'b1, 1'b0, 1'b0);
    chk("co_addr3", wr_addr, 2);
    cyc(1'b1, 1'b1, 1'b1);
    chk("cv_we", wr_we, 0);
    chk("cv_y", y_index, 0);
    chk("cv_x", x_index, 0);
    chk("cv_rot", rd_rot, 0);
    chk("cv_state", state_dbg, 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("cv_we_next", wr_we, 4'b0001);
    chk("cv_addr_next", wr_addr, 0);
    cyc(1'b0, 1'b0, 1'b0);

    // asynchronous reset in the middle of a line
    vs_pulse();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("mid_x", x_index, 5);
    #2 rst = 1'b1;
    #1;
    chk("arst_outs", {wr_addr, wr_we, rd_addr, rd_rot, x_index, y_index,
                      win_valid, pad_o, ovf_o, dv_o, hs_o, vs_o}, 64'd0);
    chk("arst_state", state_dbg, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    chk("post_rst_we", wr_we, 4'b0001);
    chk("post_rst_addr", wr_addr, 0);
    chk("post_rst_x", x_index, 1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
